// File: rtl/ws_pixel_rx.sv
// ws_pixel_rx: single-wire LED-strip pixel receiver and frame decoder; define WS_RX_RGB_EN to present pixels as {R,G,B}
module ws_pixel_rx #(
  parameter int NUM_PIX    = 61,
  parameter int BIT_THRESH = 30,
  parameter int MAX_HIGH   = 75,
  parameter int RESET_CYC  = 2500,
  parameter int CNT_W      = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] pix_data,
  output logic [5:0]  pix_addr,
  output logic        pix_valid,
  output logic        frame_done,
  output logic [6:0]  frame_len,
  output logic        err
);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] THR  = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] MAXH = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] GAP  = CNT_W'(RESET_CYC);
  localparam logic [6:0]       NP   = 7'(NUM_PIX);
  typedef enum logic [1:0] {SYNC, READY, LOW, HIGH} state_t;
  state_t state, state_n;
  logic s1, s2, s3, rise, fall, take, take_n, pix_valid_n, frame_done_n, err_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [4:0] bit_cnt, bit_cnt_n;
  logic [23:0] shreg, shreg_n, pix_word, pix_data_n;
  logic [6:0] idx, idx_n, frame_len_n;
  logic [5:0] pix_addr_n;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign cnt_inc = &cnt ? cnt : cnt + ONE;
`ifdef WS_RX_RGB_EN
  assign pix_word = {shreg[15:8], shreg[23:16], shreg[7:0]};
`else
  assign pix_word = shreg;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      {s1, s2, s3} <= '0;
      state <= SYNC;
      cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      idx <= '0;
      take <= 1'b0;
      pix_data <= '0;
      pix_addr <= '0;
      pix_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_len <= '0;
      err <= 1'b0;
    end else begin
      {s1, s2, s3} <= {din, s1, s2};
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg <= shreg_n;
      idx <= idx_n;
      take <= take_n;
      pix_data <= pix_data_n;
      pix_addr <= pix_addr_n;
      pix_valid <= pix_valid_n;
      frame_done <= frame_done_n;
      frame_len <= frame_len_n;
      err <= err_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt_inc;
    bit_cnt_n = bit_cnt == 5'd24 ? '0 : bit_cnt;
    shreg_n = shreg;
    take_n = bit_cnt == 5'd24;
    pix_valid_n = take && idx < NP;
    idx_n = pix_valid_n ? idx + 7'd1 : idx;
    pix_data_n = pix_valid_n ? pix_word : pix_data;
    pix_addr_n = pix_valid_n ? idx[5:0] : pix_addr;
    err_n = take && idx >= NP;
    frame_done_n = 1'b0;
    frame_len_n = frame_len;
    case (state)
      SYNC: begin
        cnt_n = s2 ? '0 : cnt_inc;
        state_n = !s2 && cnt_inc == GAP ? READY : SYNC;
      end
      READY: begin
        state_n = rise ? HIGH : READY;
        cnt_n = rise ? ONE : cnt_inc;
      end
      LOW: begin
        if (cnt_inc == GAP) begin
          state_n = READY;
          frame_done_n = 1'b1;
          frame_len_n = idx;
          err_n = err_n | (bit_cnt != 5'd0);
          bit_cnt_n = '0;
          idx_n = '0;
          pix_addr_n = '0;
        end
        if (rise) begin
          state_n = HIGH;
          cnt_n = ONE;
        end
      end
      HIGH: begin
        if (fall) begin
          shreg_n = {shreg[22:0], cnt > THR};
          bit_cnt_n = bit_cnt + 5'd1;
          state_n = LOW;
          cnt_n = ONE;
        end else if (cnt_inc > MAXH) begin
          err_n = 1'b1;
          bit_cnt_n = '0;
          idx_n = '0;
          state_n = SYNC;
          cnt_n = '0;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_ws_pixel_rx.sv
// tb_ws_pixel_rx: randomized self-checking bench for ws_pixel_rx against a protocol-level model
module tb_ws_pixel_rx;
  logic clk = 1'b0, reset = 1'b1, din = 1'b0;
  logic [23:0] pix_data;
  logic [5:0] pix_addr;
  logic pix_valid, frame_done, err;
  logic [6:0] frame_len;
  int total = 0, bad = 0, cyc = 0, last_low = 0;
  logic [23:0] v_data[$];
  logic [5:0] v_addr[$];
  int v_cyc[$];
  logic [6:0] f_len[$];
  int f_cyc[$];
  int e_cyc[$];
  logic [23:0] x_data[$];
  int x_cyc[$];
  ws_pixel_rx dut (
    .clk(clk), .reset(reset), .din(din), .pix_data(pix_data), .pix_addr(pix_addr),
    .pix_valid(pix_valid), .frame_done(frame_done), .frame_len(frame_len), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (pix_valid) begin
      v_data.push_back(pix_data);
      v_addr.push_back(pix_addr);
      v_cyc.push_back(cyc);
    end
    if (frame_done) begin
      f_len.push_back(frame_len);
      f_cyc.push_back(cyc);
    end
    if (err) e_cyc.push_back(cyc);
  end
  initial begin
    #1500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  function automatic logic [23:0] out_order(logic [23:0] w);
`ifdef WS_RX_RGB_EN
    return {w[15:8], w[23:16], w[7:0]};
`else
    return w;
`endif
  endfunction
  task automatic clear_q();
    v_data.delete(); v_addr.delete(); v_cyc.delete();
    f_len.delete(); f_cyc.delete(); e_cyc.delete();
    x_data.delete(); x_cyc.delete();
  endtask
  task automatic pulse(int h, int l);
    din = 1'b1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    last_low = cyc;
    repeat (l) @(negedge clk);
  endtask
  task automatic send_bit(logic b, int mode);
    int h, l;
    if (mode == 0) begin
      h = b ? 45 : 15;
      l = b ? 15 : 45;
    end else if (mode == 1) begin
      h = b ? 31 : 2;
      l = 2;
    end else begin
      h = b ? int'($urandom_range(31, 50)) : int'($urandom_range(1, 30));
      l = int'($urandom_range(2, 20));
    end
    pulse(h, l);
  endtask
  task automatic send_pixel(logic [23:0] w, int mode);
    for (int i = 23; i >= 0; i--) send_bit(w[i], mode);
    x_data.push_back(w);
    x_cyc.push_back(last_low + 5);
  endtask
  task automatic gap(int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL rst_pix_valid got=%b want=0", pix_valid); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b want=0", frame_done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
    total++; if (pix_data !== 24'h0) begin bad++; $display("FAIL rst_pix_data got=%h want=0", pix_data); end
    total++; if (pix_addr !== 6'h0) begin bad++; $display("FAIL rst_pix_addr got=%0d want=0", pix_addr); end
    total++; if (frame_len !== 7'h0) begin bad++; $display("FAIL rst_frame_len got=%0d want=0", frame_len); end
    clear_q();
    reset = 1'b0;
    gap(2500);
    total++; if (f_len.size() != 0) begin bad++; $display("FAIL sync_gap_frame_done got=%0d want=0", f_len.size()); end
    total++; if (e_cyc.size() != 0) begin bad++; $display("FAIL sync_gap_err got=%0d want=0", e_cyc.size()); end
  endtask
  task automatic test_single();
    logic [23:0] want;
`ifdef WS_RX_RGB_EN
    want = 24'hC3A5F0;
`else
    want = 24'hA5C3F0;
`endif
    clear_q();
    send_pixel(24'hA5C3F0, 0);
    gap(2505);
    total++; if (v_data.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", v_data.size()); end
    if (v_data.size() > 0) begin
      total++; if (v_data[0] !== want) begin bad++; $display("FAIL single_data got=%h want=%h", v_data[0], want); end
      total++; if (v_addr[0] !== 6'd0) begin bad++; $display("FAIL single_addr got=%0d want=0", v_addr[0]); end
      total++; if (v_cyc[0] != x_cyc[0]) begin bad++; $display("FAIL single_latency got=%0d want=%0d", v_cyc[0], x_cyc[0]); end
    end
    total++; if (f_len.size() != 1) begin bad++; $display("FAIL single_fd_count got=%0d want=1", f_len.size()); end
    if (f_len.size() > 0) begin
      total++; if (f_len[0] !== 7'd1) begin bad++; $display("FAIL single_frame_len got=%0d want=1", f_len[0]); end
    end
    total++; if (e_cyc.size() != 0) begin bad++; $display("FAIL single_err got=%0d want=0", e_cyc.size()); end
  endtask
  task automatic test_full_frame();
    logic [7:0] b;
    clear_q();
    for (int n = 0; n < 61; n++) begin
      b = 8'(n);
      send_pixel({b, ~b, b}, 1);
    end
    gap(2505);
    total++; if (v_data.size() != 61) begin bad++; $display("FAIL full_count got=%0d want=61", v_data.size()); end
    for (int i = 0; i < v_data.size() && i < 61; i++) begin
      total++; if (v_addr[i] !== 6'(i)) begin bad++; $display("FAIL full_addr[%0d] got=%0d want=%0d", i, v_addr[i], i); end
      total++; if (v_data[i] !== out_order(x_data[i])) begin bad++; $display("FAIL full_data[%0d] got=%h want=%h", i, v_data[i], out_order(x_data[i])); end
      total++; if (v_cyc[i] != x_cyc[i]) begin bad++; $display("FAIL full_latency[%0d] got=%0d want=%0d", i, v_cyc[i], x_cyc[i]); end
    end
    total++; if (f_len.size() != 1) begin bad++; $display("FAIL full_fd_count got=%0d want=1", f_len.size()); end
    if (f_len.size() > 0) begin
      total++; if (f_len[0] !== 7'd61) begin bad++; $display("FAIL full_frame_len got=%0d want=61", f_len[0]); end
    end
    total++; if (e_cyc.size() != 0) begin bad++; $display("FAIL full_err got=%0d want=0", e_cyc.size()); end
  endtask
  task automatic test_overflow();
    clear_q();
    for (int n = 0; n < 63; n++) send_pixel(24'($urandom & 32'h0003_0003), 1);
    gap(2505);
    total++; if (v_data.size() != 61) begin bad++; $display("FAIL ovf_count got=%0d want=61", v_data.size()); end
    for (int i = 0; i < v_data.size() && i < 61; i++) begin
      total++; if (v_addr[i] !== 6'(i)) begin bad++; $display("FAIL ovf_addr[%0d] got=%0d want=%0d", i, v_addr[i], i); end
      total++; if (v_data[i] !== out_order(x_data[i])) begin bad++; $display("FAIL ovf_data[%0d] got=%h want=%h", i, v_data[i], out_order(x_data[i])); end
    end
    total++; if (e_cyc.size() != 2) begin bad++; $display("FAIL ovf_err_count got=%0d want=2", e_cyc.size()); end
    for (int k = 0; k < e_cyc.size() && k < 2; k++) begin
      total++; if (e_cyc[k] != x_cyc[61+k]) begin bad++; $display("FAIL ovf_err_cyc[%0d] got=%0d want=%0d", k, e_cyc[k], x_cyc[61+k]); end
    end
    total++; if (f_len.size() != 1) begin bad++; $display("FAIL ovf_fd_count got=%0d want=1", f_len.size()); end
    if (f_len.size() > 0) begin
      total++; if (f_len[0] !== 7'd61) begin bad++; $display("FAIL ovf_frame_len got=%0d want=61", f_len[0]); end
    end
  endtask
  task automatic test_partial();
    logic [23:0] w;
    clear_q();
    w = 24'($urandom);
    for (int i = 23; i >= 14; i--) send_bit(w[i], 1);
    total++; if (frame_len !== 7'd61) begin bad++; $display("FAIL partial_len_held got=%0d want=61", frame_len); end
    gap(2505);
    total++; if (f_len.size() != 1) begin bad++; $display("FAIL partial_fd_count got=%0d want=1", f_len.size()); end
    total++; if (e_cyc.size() != 1) begin bad++; $display("FAIL partial_err_count got=%0d want=1", e_cyc.size()); end
    if (f_len.size() > 0 && e_cyc.size() > 0) begin
      total++; if (f_len[0] !== 7'd0) begin bad++; $display("FAIL partial_frame_len got=%0d want=0", f_len[0]); end
      total++; if (e_cyc[0] != f_cyc[0]) begin bad++; $display("FAIL partial_err_cycle got=%0d want=%0d", e_cyc[0], f_cyc[0]); end
    end
    total++; if (v_data.size() != 0) begin bad++; $display("FAIL partial_valid got=%0d want=0", v_data.size()); end
    clear_q();
    send_pixel(24'($urandom), 1);
    gap(2505);
    total++; if (v_data.size() != 1) begin bad++; $display("FAIL partial_next_count got=%0d want=1", v_data.size()); end
    if (v_data.size() > 0) begin
      total++; if (v_addr[0] !== 6'd0) begin bad++; $display("FAIL partial_next_addr got=%0d want=0", v_addr[0]); end
      total++; if (v_data[0] !== out_order(x_data[0])) begin bad++; $display("FAIL partial_next_data got=%h want=%h", v_data[0], out_order(x_data[0])); end
    end
  endtask
  task automatic test_boundary();
    logic [23:0] w;
    clear_q();
    for (int k = 0; k < 2; k++) begin
      w = {1'b1, 22'($urandom), 1'b0};
      for (int i = 23; i >= 0; i--) pulse(w[i] ? (k == 0 ? 31 : 75) : (k == 0 ? 30 : 1), 3);
      x_data.push_back(w);
      x_cyc.push_back(last_low + 5);
    end
    gap(2505);
    total++; if (v_data.size() != 2) begin bad++; $display("FAIL bound_count got=%0d want=2", v_data.size()); end
    for (int i = 0; i < v_data.size() && i < 2; i++) begin
      total++; if (v_data[i] !== out_order(x_data[i])) begin bad++; $display("FAIL bound_data[%0d] got=%h want=%h", i, v_data[i], out_order(x_data[i])); end
      total++; if (v_addr[i] !== 6'(i)) begin bad++; $display("FAIL bound_addr[%0d] got=%0d want=%0d", i, v_addr[i], i); end
    end
    total++; if (e_cyc.size() != 0) begin bad++; $display("FAIL bound_err got=%0d want=0", e_cyc.size()); end
  endtask
  task automatic test_long_high();
    clear_q();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1);
    pulse(80, 10);
    send_pixel(24'($urandom), 1);
    gap(2505);
    total++; if (e_cyc.size() != 1) begin bad++; $display("FAIL long_err_count got=%0d want=1", e_cyc.size()); end
    total++; if (v_data.size() != 0) begin bad++; $display("FAIL long_ignored got=%0d want=0", v_data.size()); end
    total++; if (f_len.size() != 0) begin bad++; $display("FAIL long_fd got=%0d want=0", f_len.size()); end
    clear_q();
    send_pixel(24'($urandom), 1);
    gap(2505);
    total++; if (v_data.size() != 1) begin bad++; $display("FAIL long_next_count got=%0d want=1", v_data.size()); end
    if (v_data.size() > 0) begin
      total++; if (v_data[0] !== out_order(x_data[0])) begin bad++; $display("FAIL long_next_data got=%h want=%h", v_data[0], out_order(x_data[0])); end
      total++; if (v_addr[0] !== 6'd0) begin bad++; $display("FAIL long_next_addr got=%0d want=0", v_addr[0]); end
    end
    total++; if (f_len.size() != 1 || (f_len.size() == 1 && f_len[0] !== 7'd1)) begin bad++; $display("FAIL long_next_fd got=%0d want=1 frame", f_len.size()); end
  endtask
  task automatic test_reset_mid();
    clear_q();
    for (int i = 0; i < 12; i++) send_bit(1'($urandom), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send_pixel(24'($urandom), 1);
    total++; if (v_data.size() + f_len.size() + e_cyc.size() != 0) begin bad++; $display("FAIL rmid_strobes got=%0d want=0", v_data.size() + f_len.size() + e_cyc.size()); end
    clear_q();
    gap(2500);
    send_pixel(24'($urandom), 1);
    gap(2505);
    total++; if (v_data.size() != 1) begin bad++; $display("FAIL rmid_count got=%0d want=1", v_data.size()); end
    if (v_data.size() > 0) begin
      total++; if (v_data[0] !== out_order(x_data[0])) begin bad++; $display("FAIL rmid_data got=%h want=%h", v_data[0], out_order(x_data[0])); end
      total++; if (v_addr[0] !== 6'd0) begin bad++; $display("FAIL rmid_addr got=%0d want=0", v_addr[0]); end
      total++; if (v_cyc[0] != x_cyc[0]) begin bad++; $display("FAIL rmid_latency got=%0d want=%0d", v_cyc[0], x_cyc[0]); end
    end
    total++; if (e_cyc.size() != 0) begin bad++; $display("FAIL rmid_err got=%0d want=0", e_cyc.size()); end
  endtask
  task automatic test_random();
    int n;
    for (int f = 0; f < 2; f++) begin
      clear_q();
      n = int'($urandom_range(1, 3));
      for (int p = 0; p < n; p++) send_pixel(24'($urandom), 2);
      gap(2505);
      total++; if (v_data.size() != n) begin bad++; $display("FAIL rand_count got=%0d want=%0d", v_data.size(), n); end
      for (int i = 0; i < v_data.size() && i < n; i++) begin
        total++; if (v_data[i] !== out_order(x_data[i])) begin bad++; $display("FAIL rand_data[%0d] got=%h want=%h", i, v_data[i], out_order(x_data[i])); end
        total++; if (v_addr[i] !== 6'(i)) begin bad++; $display("FAIL rand_addr[%0d] got=%0d want=%0d", i, v_addr[i], i); end
        total++; if (v_cyc[i] != x_cyc[i]) begin bad++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, v_cyc[i], x_cyc[i]); end
      end
      total++; if (f_len.size() != 1 || (f_len.size() == 1 && f_len[0] !== 7'(n))) begin bad++; $display("FAIL rand_fd frames=%0d want=1 frame of %0d", f_len.size(), n); end
      total++; if (e_cyc.size() != 0) begin bad++; $display("FAIL rand_err got=%0d want=0", e_cyc.size()); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_full_frame();
    test_overflow();
    test_partial();
    test_boundary();
    test_long_high();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ws_pixel_rx.md
Name: ws_pixel_rx

Overview:
- Receiver and decoder for the single-wire LED-strip serial protocol emitted by the strip driver (`band_drive`).
- Measures pulse widths on `din`, rebuilds 24-bit pixel words MSB-first, and presents them with a pixel index, one pixel per `pix_valid` strobe.
- Detects the latch (reset-low) gap that ends a frame and reports the number of pixels received.
- Used as an in-system loopback checker on the strip data line and as a stand-in for a strip in simulation.

Parameters:
- NUM_PIX, 61, pixels accepted per frame; indices 0..NUM_PIX-1.
- BIT_THRESH, 30, high-time threshold in clk cycles; high time > BIT_THRESH decodes as 1, otherwise 0.
- MAX_HIGH, 75, longest legal high time in clk cycles; longer is a protocol error.
- RESET_CYC, 2500, consecutive low cycles that constitute the latch gap.
- CNT_W, 12, width of the pulse-width counter; must hold RESET_CYC.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  1  serial strip data, asynchronous to clk.
- pix_data  output  24  decoded pixel, first received bit in bit 23.
- pix_addr  output  6  index of pixel in pix_data, 0 = first pixel after latch.
- pix_valid  output  1  one-cycle strobe; pix_data/pix_addr valid this cycle.
- frame_done  output  1  one-cycle strobe at end of latch gap.
- frame_len  output  7  pixels delivered in the frame just closed; valid with frame_done, held until the next frame_done.
- err  output  1  one-cycle strobe on any protocol error.

Behaviour:
- Reset: all outputs 0, state SYNC, counters 0, synchronizer flops 0.
- Input synchronizer: two flops `s1` and `s2`, plus one delay flop `s3`.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- State SYNC: ignore all edges until s2 has been low for RESET_CYC consecutive cycles, then go to READY. No frame_done is issued for this first gap.
- State READY / LOW, on rise: go to HIGH with width counter = 1.
- State LOW, no rise: increment width counter (saturating).
  - When it reaches RESET_CYC: go to READY.
  - Pulse frame_done and load frame_len = pixels delivered in this frame.
  - If bit_cnt != 0, also pulse err in the same cycle and discard the partial pixel.
  - Clear pix_addr and bit_cnt.
- State HIGH: increment width counter.
  - If it exceeds MAX_HIGH: pulse err, discard the partial pixel, go to SYNC.
- State HIGH, on fall: bit = (width > BIT_THRESH); shift it into a 24-bit shift register from the LSB; bit_cnt++; go to LOW with width counter = 1.
- On the 24th bit: the next cycle drives pix_valid=1 and pix_data = shift register, with pix_addr = current index; then the index increments and bit_cnt returns to 0.
- Latency: pix_valid is high exactly 4 clk after the first rising clk edge at which din is sampled low ending bit 24. The bench checks this as a fixed value.
- Overflow: pixels with index ≥ NUM_PIX are decoded but not presented.
  - Each such pixel produces an err strobe instead of pix_valid.
  - The index saturates at NUM_PIX, so frame_len ≤ NUM_PIX.
- Low time is not checked against a minimum; only high time is qualified.
- Simultaneous events: a rise in the same cycle the low counter reaches RESET_CYC is treated as the latch completing first. The rise starts the next frame's first bit and is not lost.
- Reset mid-frame: synchronous reset returns to SYNC immediately. No strobes are issued and the partial pixel is dropped.
- Counter widths: the width counter is CNT_W bits and saturates at all-ones. Comparisons are unsigned.

Optional Feature:
- Macro: WS_RX_RGB_EN.
- Defined: pix_data is reordered from wire order {G,R,B} to {R,G,B}, i.e. pix_data = {w[15:8], w[23:16], w[7:0]}. Latency is unchanged.
- Undefined: pix_data is raw wire order.

Test Plan:
- Reset, din low 2500 cycles, then 24 bits of 0xA5C3F0 (1 = 45 high/15 low, 0 = 15 high/45 low), then low 2500 → pix_valid once with pix_data=0xA5C3F0, pix_addr=0 (0xC3A5F0 with WS_RX_RGB_EN); frame_done with frame_len=1; no err.
- Frame of 61 pixels with pixel n = {n, ~n, n} (8-bit n) then latch → 61 strobes, addresses 0..60 in order, data matches; frame_len=61.
- 63 pixels then latch → 61 pix_valid, 2 err strobes, frame_len=61.
- 10 bits then low 2500 → frame_done with frame_len=0 plus err in the same cycle; next full pixel decodes at pix_addr=0.
- High pulse of 80 cycles mid-pixel → err once, no pix_valid; a new pixel is ignored until 2500 low cycles, then decodes correctly. Boundary checks: high width 30 decodes 0, 31 decodes 1.
- Assert reset for 1 cycle after 12 bits → no strobes; the bench must re-issue the latch gap before the next pixel is accepted.
